// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register slave: NUM_REGS data-wide registers with per-register read-only masking.
// Write and read channels run as independent FSMs; one transaction of each kind in flight.
module axi4lite_reg_slave #(
  parameter int                  ADDR_W   = 5,
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_areset,
  input  logic [ADDR_W-1:0]            s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_W-1:0]            s_axi_wdata,
  input  logic [DATA_W/8-1:0]          s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_W-1:0]            s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [DATA_W-1:0]            s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_RESP}           r_state_e;

  w_state_e                           w_state_q, w_state_d;
  r_state_e                           r_state_q, r_state_d;
  logic                               aw_held_q, aw_held_d;
  logic                               w_held_q, w_held_d;
  logic [IDX_W-1:0]                   aw_idx_q, aw_idx_d;
  logic [DATA_W-1:0]                  wdata_q, wdata_d;
  logic [STRB_W-1:0]                  wstrb_q, wstrb_d;
  logic                               awready_q, awready_d;
  logic                               wready_q, wready_d;
  logic                               bvalid_q, bvalid_d;
  logic [1:0]                         bresp_q, bresp_d;
  logic [NUM_REGS-1:0]                wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;
  logic                               arready_q, arready_d;
  logic                               rvalid_q, rvalid_d;
  logic [DATA_W-1:0]                  rdata_q, rdata_d;
  logic [1:0]                         rresp_q, rresp_d;

  logic                               wr_ok;
  logic                               rd_ok;
  logic [DATA_W-1:0]                  rd_data;
  logic [IDX_W-1:0]                   ar_idx;

  // Byte-offset bits carry no meaning for a word-addressed register file.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

  assign ar_idx = s_axi_araddr[ADDR_W-1:LSB];

  always_comb begin
    // NOTE: every value driven here gets a default first, so no path can leave one unassigned and infer a latch.
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;

    // Only in-range, writable registers accept data; everything else answers SLVERR.
    wr_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx_q == IDX_W'(i) && !RO_MASK[i]) wr_ok = 1'b1;
    end

    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s_axi_awaddr[ADDR_W-1:LSB];
        end
        if (s_axi_wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        if (aw_held_d && w_held_d) w_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_ok && aw_idx_q == IDX_W'(i)) begin
            wr_pulse_d[i] = 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (wstrb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
            end
          end
        end
        bvalid_d  = 1'b1;
        bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    // Sampled from the current register state, so a same-cycle commit is not visible yet.
    rd_ok   = 1'b0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_ok   = 1'b1;
        rd_data = RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : regs_q[i];
      end
    end

    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          rdata_d   = rd_data;
          rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      wr_pulse_q <= '0;
      // NOTE: the register file lives in flops and is cleared here, so software always sees zeros after reset.
      regs_q     <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of statement order.
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign wr_pulse      = wr_pulse_q;
  assign reg_out       = regs_q;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Scoreboard bench: two slaves (8 regs with reg 7 read-only, and 6 regs) share one AXI bus;
// expected responses are queued when a transaction is driven and popped when the slave answers.
module tb_axi4lite_reg_slave;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NA = 8;
  localparam int NB = 6;
  localparam logic [NA-1:0] RO_A = 8'h80;

  logic              clk = 1'b0;
  logic              areset = 1'b1;
  logic [AW-1:0]     awaddr = '0;
  logic              awvalid = 1'b0;
  logic [DW-1:0]     wdata = '0;
  logic [DW/8-1:0]   wstrb = '0;
  logic              wvalid = 1'b0;
  logic              bready = 1'b0;
  logic [AW-1:0]     araddr = '0;
  logic              arvalid = 1'b0;
  logic              rready = 1'b0;
  logic [NA*DW-1:0]  reg_in;

  logic              a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
  logic [1:0]        a_bresp, a_rresp;
  logic [DW-1:0]     a_rdata;
  logic [NA*DW-1:0]  a_reg_out;
  logic [NA-1:0]     a_wr_pulse;

  logic              b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
  logic [1:0]        b_bresp, b_rresp;
  logic [DW-1:0]     b_rdata;
  logic [NB*DW-1:0]  b_reg_out;
  logic [NB-1:0]     b_wr_pulse;

  always #5 clk = ~clk;

  axi4lite_reg_slave #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NA), .RO_MASK(RO_A)) dut_a (
    .s_axi_aclk(clk), .s_axi_areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(a_awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(a_wready),
    .s_axi_bresp(a_bresp), .s_axi_bvalid(a_bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(a_arready),
    .s_axi_rdata(a_rdata), .s_axi_rresp(a_rresp), .s_axi_rvalid(a_rvalid), .s_axi_rready(rready),
    .reg_out(a_reg_out), .reg_in(reg_in), .wr_pulse(a_wr_pulse)
  );

  axi4lite_reg_slave #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NB), .RO_MASK(6'h00)) dut_b (
    .s_axi_aclk(clk), .s_axi_areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(b_awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(b_wready),
    .s_axi_bresp(b_bresp), .s_axi_bvalid(b_bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(b_arready),
    .s_axi_rdata(b_rdata), .s_axi_rresp(b_rresp), .s_axi_rvalid(b_rvalid), .s_axi_rready(rready),
    .reg_out(b_reg_out), .reg_in(reg_in[NB*DW-1:0]), .wr_pulse(b_wr_pulse)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rd_exp_t;

  logic [1:0]    qa_b[$];
  logic [1:0]    qb_b[$];
  rd_exp_t       qa_r[$];
  rd_exp_t       qb_r[$];
  logic [DW-1:0] model_a[NA];
  logic [DW-1:0] model_b[NB];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < NA; i++) model_a[i] = '0;
    for (int i = 0; i < NB; i++) model_b[i] = '0;
  endtask

  task automatic check_reg_out(input string tag);
    for (int i = 0; i < NA; i++)
      check($sformatf("%s_a%0d", tag, i), a_reg_out[i*DW +: DW], model_a[i]);
    for (int i = 0; i < NB; i++)
      check($sformatf("%s_b%0d", tag, i), b_reg_out[i*DW +: DW], model_b[i]);
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input int aw_start, input int w_start,
                           input int bready_wait);
    int         idx;
    int         cyc;
    logic       ok_a, ok_b, hs_aw, hs_w, aw_done, w_done;
    logic [1:0] exp_a, exp_b;
    idx  = int'(addr[AW-1:2]);
    ok_a = !RO_A[idx];
    ok_b = (idx < NB);
    qa_b.push_back(ok_a ? 2'b00 : 2'b10);
    qb_b.push_back(ok_b ? 2'b00 : 2'b10);
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= aw_start);
      wvalid  = !w_done && (cyc >= w_start);
      hs_aw   = awvalid && a_awready;
      hs_w    = wvalid && a_wready;
      @(negedge clk);
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("wr_handshake", 64'(aw_done && w_done), 1);
    check("bvalid_early", a_bvalid, 0);
    check("awready_commit", a_awready, 0);
    @(negedge clk);
    exp_a = qa_b.pop_front();
    exp_b = qb_b.pop_front();
    check("bvalid_rise", a_bvalid, 1);
    check("b_bvalid_rise", b_bvalid, 1);
    check("bresp", a_bresp, exp_a);
    check("b_bresp", b_bresp, exp_b);
    check("wr_pulse", a_wr_pulse, ok_a ? (64'd1 << idx) : 64'd0);
    check("b_wr_pulse", b_wr_pulse, ok_b ? (64'd1 << idx) : 64'd0);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        if (ok_a) model_a[idx][8*b +: 8] = data[8*b +: 8];
        if (ok_b) model_b[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
    check_reg_out("reg_out");
    for (int k = 0; k < bready_wait; k++) begin
      @(negedge clk);
      check("bvalid_hold", a_bvalid, 1);
      check("bresp_hold", a_bresp, exp_a);
      check("awready_hold", a_awready, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_fall", a_bvalid, 0);
    check("wr_pulse_clear", a_wr_pulse, 0);
    check("awready_back", a_awready, 1);
    check("wready_back", a_wready, 1);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int rready_wait);
    int      idx;
    rd_exp_t ea, eb;
    idx     = int'(addr[AW-1:2]);
    ea.resp = 2'b00;
    ea.data = RO_A[idx] ? reg_in[idx*DW +: DW] : model_a[idx];
    if (idx < NB) begin
      eb.data = model_b[idx];
      eb.resp = 2'b00;
    end else begin
      eb.data = '0;
      eb.resp = 2'b10;
    end
    qa_r.push_back(ea);
    qb_r.push_back(eb);
    araddr  = addr;
    arvalid = 1'b1;
    check("arready_idle", a_arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    ea = qa_r.pop_front();
    eb = qb_r.pop_front();
    check("rvalid_rise", a_rvalid, 1);
    check("arready_busy", a_arready, 0);
    check("rdata", a_rdata, ea.data);
    check("rresp", a_rresp, ea.resp);
    check("b_rdata", b_rdata, eb.data);
    check("b_rresp", b_rresp, eb.resp);
    for (int k = 0; k < rready_wait; k++) begin
      @(negedge clk);
      check("rvalid_hold", a_rvalid, 1);
      check("rdata_hold", a_rdata, ea.data);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rvalid_fall", a_rvalid, 0);
    check("arready_back", a_arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NA; i++) reg_in[i*DW +: DW] = 32'hDEAD0000 | 32'(i);
    reg_in[255:224] = 32'hBEEFF00D;
    clear_models();

    repeat (3) @(negedge clk);
    check("rst_awready", a_awready, 0);
    check("rst_wready", a_wready, 0);
    check("rst_arready", a_arready, 0);
    check("rst_bvalid", a_bvalid, 0);
    check("rst_rvalid", a_rvalid, 0);
    check("rst_wr_pulse", a_wr_pulse, 0);
    check_reg_out("rst_reg_out");
    areset = 1'b0;
    @(negedge clk);
    check("post_rst_awready", a_awready, 1);
    check("post_rst_wready", a_wready, 1);
    check("post_rst_arready", a_arready, 1);

    // Same-cycle AW/W, then read back.
    axi_write(5'h04, 32'hA5A51234, 4'hF, 0, 0, 0);
    axi_read(5'h04, 0);

    // W presented three cycles before AW, partial strobe.
    axi_write(5'h08, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(5'h08, 32'hFFFFFFFF, 4'h3, 3, 0, 0);
    axi_read(5'h08, 2);
    check("req022_reg2", a_reg_out[2*DW +: DW], 32'h1122FFFF);

    // Read-only register 7.
    axi_write(5'h1C, 32'hCAFEBABE, 4'hF, 0, 0, 0);
    axi_read(5'h1C, 0);

    // Index 6: in range for the 8-register slave, out of range for the 6-register one.
    axi_read(5'h18, 0);
    axi_write(5'h18, 32'h66666666, 4'hF, 0, 0, 0);
    axi_read(5'h18, 1);

    // Slow bready; AW before W.
    axi_write(5'h0C, 32'h0C0C0C0C, 4'hF, 0, 2, 5);
    axi_write(5'h10, 32'h87654321, 4'hA, 0, 1, 0);
    axi_read(5'h11, 0);

    for (int n = 0; n < 12; n++) begin
      axi_write(AW'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      axi_read(AW'($urandom_range(0, 31)), $urandom_range(0, 2));
    end

    // Read sampled on the commit edge of a write to the same register sees the old value.
    axi_write(5'h14, 32'h55555555, 4'hF, 0, 0, 0);
    fork
      axi_write(5'h14, 32'h9ABCDEF0, 4'hF, 0, 0, 0);
      begin
        @(negedge clk);
        axi_read(5'h14, 0);
      end
    join
    axi_read(5'h14, 0);

    // Reset with a read response pending and a write in W_COMMIT.
    axi_write(5'h0C, 32'h13579BDF, 4'hF, 0, 0, 0);
    araddr  = 5'h04;
    arvalid = 1'b1;
    awaddr  = 5'h0C;
    wdata   = 32'h2468ACE0;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("pre_rst_rvalid", a_rvalid, 1);
    areset = 1'b1;
    @(negedge clk);
    clear_models();
    check("rst2_rvalid", a_rvalid, 0);
    check("rst2_rdata", a_rdata, 0);
    check("rst2_bvalid", a_bvalid, 0);
    check("rst2_wr_pulse", a_wr_pulse, 0);
    check("rst2_awready", a_awready, 0);
    check("rst2_arready", a_arready, 0);
    check_reg_out("rst2_reg_out");
    areset = 1'b0;
    @(negedge clk);
    check("rst2_wr_pulse_after", a_wr_pulse, 0);
    check("rst2_awready_back", a_awready, 1);
    check("rst2_wready_back", a_wready, 1);
    check("rst2_arready_back", a_arready, 1);
    check_reg_out("rst2_reg_out_after");
    axi_read(5'h0C, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4lite_reg_slave.md
AXI4LITE_REG_SLAVE -- requirements
Module: axi4lite_reg_slave

Interface
REQ-001 The block SHALL have one clock, s_axi_aclk; reset s_axi_areset SHALL be synchronous and active-high.
REQ-002 Parameters SHALL be as follows, one per line:
- ADDR_W, default 5, byte address width.
- DATA_W, default 32, data width; legal values are 32 or 64.
- NUM_REGS, default 8, register count; NUM_REGS*DATA_W/8 <= 2^ADDR_W.
- RO_MASK, default 0, NUM_REGS bits; bit i = 1 makes register i read-only.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- s_axi_aclk, in, 1, clock.
- s_axi_areset, in, 1, synchronous active-high reset.
- s_axi_awaddr, in, ADDR_W, write address.
- s_axi_awvalid, in, 1; s_axi_awready, out, 1.
- s_axi_wdata, in, DATA_W; s_axi_wstrb, in, DATA_W/8, byte enables.
- s_axi_wvalid, in, 1; s_axi_wready, out, 1.
- s_axi_bresp, out, 2; s_axi_bvalid, out, 1; s_axi_bready, in, 1.
- s_axi_araddr, in, ADDR_W; s_axi_arvalid, in, 1; s_axi_arready, out, 1.
- s_axi_rdata, out, DATA_W; s_axi_rresp, out, 2; s_axi_rvalid, out, 1; s_axi_rready, in, 1.
- reg_out, out, NUM_REGS*DATA_W, RW register contents; slice i = register i.
- reg_in, in, NUM_REGS*DATA_W, read value for RO registers.
- wr_pulse, out, NUM_REGS, one-cycle pulse per successful write.

Function
REQ-004 Register index SHALL be addr[ADDR_W-1:log2(DATA_W/8)]; low address bits SHALL be ignored.
REQ-005 The write path SHALL have three states: W_IDLE, W_COMMIT and W_RESP.
REQ-006 In W_IDLE:
- awready SHALL be 1 while no AW is held.
- wready SHALL be 1 while no W is held.
- AW and W SHALL be accepted independently, in either order or in the same cycle.
- Address, data and strobe SHALL be captured at their handshakes.
REQ-007 W_IDLE SHALL go to W_COMMIT at the edge where both AW and W are held; awready and wready SHALL be 0 in W_COMMIT and W_RESP.
REQ-008 W_COMMIT SHALL last one cycle. At its closing edge:
- Bytes with strobe = 1 SHALL be updated; other bytes SHALL be unchanged.
- wr_pulse[index] SHALL be 1 for the following cycle only.
- bvalid SHALL rise.
- State SHALL go to W_RESP.
REQ-009 A write with index >= NUM_REGS, or to a register with RO_MASK[index] = 1, SHALL return bresp = 2'b10 (SLVERR), change no register and produce no wr_pulse; all other writes SHALL return bresp = 2'b00 (OKAY).
REQ-010 W_RESP SHALL hold bvalid and bresp stable until bready = 1, then go to W_IDLE with bvalid = 0 at the next cycle; only one write SHALL be outstanding at a time.
REQ-011 The read path SHALL have two states, R_IDLE and R_RESP, independent of the write path.
REQ-012 In R_IDLE, arready SHALL be 1; on an AR handshake the block SHALL:
- capture rdata from register state in the handshake cycle;
- enter R_RESP with rvalid = 1 on the next cycle;
- set arready = 0 while in R_RESP.
REQ-013 Read data SHALL come from the internal register when RO_MASK[i] = 0 and from reg_in slice i when RO_MASK[i] = 1.
REQ-014 A read with index >= NUM_REGS SHALL return rdata = 0 and rresp = 2'b10; otherwise rresp SHALL be 2'b00.
REQ-015 rvalid, rdata and rresp SHALL remain stable until rready = 1, then go to R_IDLE with rvalid = 0 the next cycle.
REQ-016 An AR handshake in the same cycle as W_COMMIT to the same register SHALL return the pre-write value.
REQ-017 RO register slices of reg_out SHALL read 0.

Reset
REQ-018 While s_axi_areset = 1 at a clock edge, the following SHALL be 0 on the next cycle:
- all internal registers;
- reg_out, wr_pulse, bvalid, rvalid, rdata, bresp, rresp;
- awready, wready, arready;
- held AW/W flags.
Both FSMs SHALL be in their IDLE state.
REQ-019 Reset SHALL override any transaction in progress, including W_COMMIT; a write interrupted by reset SHALL not update its register.
REQ-020 On the first cycle after reset deasserts, awready, wready and arready SHALL be 1.

Verification (DATA_W=32, NUM_REGS=8, RO_MASK=8'h80)
REQ-021 Write 0xA5A51234 to 0x04 with strb 0xF, AW and W in the same cycle:
- wr_pulse[1] is 1 for one cycle; bvalid rises 2 cycles after the handshake; bresp = 0.
- A read of 0x04 returns 0xA5A51234 with rresp = 0.
REQ-022 With reg 2 = 0x11223344, present W (0xFFFFFFFF, strb 0x3) 3 cycles before AW to 0x08 -> reg 2 becomes 0x1122FFFF.
REQ-023 Write to 0x1C (RO reg 7) -> bresp = 2'b10 and no wr_pulse; a read of 0x1C returns reg_in[255:224].
REQ-024 With NUM_REGS = 6, read 0x18 -> rdata = 0 and rresp = 2'b10; write 0x18 -> bresp = 2'b10.
REQ-025 Hold bready = 0 for 5 cycles -> bvalid and bresp stay stable, awready stays 0, and a second AW is accepted only after the B handshake.
REQ-026 Assert reset while rvalid = 1 and during W_COMMIT -> next cycle rvalid = 0, bvalid = 0, all registers 0, no wr_pulse.
